bram_write_arbiter: RTL and testbench
=====================================

// Module: bram_write_arbiter
// PURPOSE
// Shares one 32-bit BRAM write port (addr/din/we/ea) among N_REQ result writers.
// Requesters include the displacement saver and status/debug writers.
// Each requester presents an address and data word and holds a request.
// The block grants round-robin, holds the port stable for WR_CYCLES clocks, then pulses that requester's done.
// Sits between the post-gamma result writers and the PS-visible result BRAM.
// PARAMETERS
// N_REQ      3   number of requesters (2..8)
// WR_CYCLES  4   clocks addr/din/we held stable per write (1..15)
// PORTS
// clock      in   1          system clock, all logic on rising edge
// reset      in   1          synchronous, active-high
// req        in   N_REQ      per-requester write request (level)
// req_addr   in   N_REQ*32   byte addresses, requester i at [32*i+31:32*i]
// req_din    in   N_REQ*32   write data, requester i at [32*i+31:32*i]
// grant      out  N_REQ      one-hot, high while requester i owns the port
// wr_done    out  N_REQ      one-cycle pulse when requester i's write completes
// addr       out  32         BRAM byte address, bits [1:0] forced 0
// din        out  32         BRAM write data
// we         out  4          BRAM byte write enables (4'b1111 or 4'b0000)
// ea         out  1          BRAM port enable
// busy       out  1          high in any state other than IDLE
// BEHAVIOUR
// - Interface: one clock (clock); reset is synchronous and active-high (reset).
// - Reset values: grant=0, wr_done=0, addr=0, din=0, we=0, ea=0, busy=0.
//   - Also on reset: state=IDLE, rr_ptr=0, hold_cnt=0.
// - Reset mid-write: on the edge with reset high, we and ea go to 0.
//   - No wr_done is issued and the aborted write is not retried.
// - All outputs are registered.
// - FSM:
//   - IDLE: if any req is high, select the first set req at or after rr_ptr, wrapping modulo N_REQ.
//     - Capture its addr (with [1:0]=0) and din.
//     - Set grant[i]=1, we=4'b1111, ea=1, hold_cnt=WR_CYCLES-1.
//     - Go to WRITE.
//   - WRITE: hold addr/din/we/ea/grant constant.
//     - If hold_cnt==0, go to DONE. Otherwise decrement hold_cnt.
//   - DONE: we=0, ea=0, grant=0, wr_done[i]=1 for exactly this cycle.
//     - Set rr_ptr=(i+1) mod N_REQ and go to IDLE.
// - Latency: a req seen in IDLE on edge k gives we=1111 on cycles k+1..k+WR_CYCLES.
//   - wr_done[i] pulses on cycle k+WR_CYCLES+1.
//   - The earliest next grant is cycle k+WR_CYCLES+2.
// - Handshake:
//   - A requester holds req, addr and din until its wr_done.
//   - It drops req in the wr_done cycle or the next one, or keeps it high to request another write.
//   - req is not sampled in WRITE or DONE.
//   - Changes to req_addr/req_din after capture have no effect.
//   - A req dropped during WRITE does not abort the write.
// - Arbitration:
//   - Simultaneous requests resolve by round-robin from rr_ptr.
//   - A continuously requesting source waits at most N_REQ-1 writes.
//   - With a single requester it is granted back to back, one write every WR_CYCLES+2 clocks.
// - rr_ptr wraps from N_REQ-1 to 0.
// - grant is one-hot or zero.
// - wr_done is never high at the same time as we.
// TESTING
// 1. Reset, then req=001, addr0=0x8, din0=0xDEADBEEF:
//    -> we=1111, ea=1, addr=0x8 for 4 cycles starting 1 clk later; wr_done=001 1 clk after that.
// 2. req=111 held from reset, distinct addr/din:
//    -> grant order 001,010,100,001; wr_done pulses 6 clks apart; addr/din match the granted source.
// 3. req0 addr=0x7:
//    -> addr driven 0x4; req dropped in WRITE cycle 2 still completes with wr_done.
// 4. reset asserted in WRITE cycle 2:
//    -> next cycle we=0, ea=0, grant=0, no wr_done; after release a pending req1 is granted first (rr_ptr=0 scan).
// 5. WR_CYCLES=1, N_REQ=2, req=11 continuously:
//    -> alternating grants, we high 1 clk per write, period 3 clks.
// 6. Change req_din mid-WRITE:
//    -> din output stays at the captured value through DONE.

Source files
------------

// File: rtl/bram_write_arbiter.sv
// bram_write_arbiter
// Round-robin arbiter that shares a single 32-bit BRAM write port among
// N_REQ result writers. The winning requester's address and data are
// captured once. The port is then held stable for WR_CYCLES clocks. The
// requester receives a one-cycle wr_done pulse in the following cycle.
// All outputs are registered. Reset is synchronous and active-high.
module bram_write_arbiter #(
  parameter int N_REQ     = 3,
  parameter int WR_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*32-1:0] req_addr,
  input  logic [N_REQ*32-1:0] req_din,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    wr_done,
  output logic [31:0]         addr,
  output logic [31:0]         din,
  output logic [3:0]          we,
  output logic                ea,
  output logic                busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0]   N_REQ_W   = (IDX_W + 1)'(N_REQ);
  localparam logic [3:0]       HOLD_INIT = 4'(WR_CYCLES - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ - 1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] cur_idx_r;
  logic [3:0]       hold_cnt_r;

  logic             sel_found_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic [IDX_W-1:0] next_ptr_s;
  logic [31:0]      sel_addr_s;
  logic [31:0]      sel_din_s;

  // Round-robin scan: first asserted request at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    logic [IDX_W:0] cand_v;
    logic           hit_v;
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    cand_v      = '0;
    hit_v       = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_v      = {1'b0, rr_ptr_r} + (IDX_W + 1)'(k);
      cand_v      = (cand_v >= N_REQ_W) ? (cand_v - N_REQ_W) : cand_v;
      hit_v       = !sel_found_s && req[cand_v[IDX_W-1:0]];
      sel_idx_s   = hit_v ? cand_v[IDX_W-1:0] : sel_idx_s;
      sel_found_s = sel_found_s | hit_v;
    end
  end

  // Winner's address/data mux and the pointer value that follows the current owner
  always_comb begin
    sel_addr_s = req_addr[32*sel_idx_s +: 32];
    sel_din_s  = req_din[32*sel_idx_s +: 32];
    if (cur_idx_r == LAST_IDX) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = cur_idx_r + 1'b1;
    end
  end

  // Control FSM and all registered port outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= '0;
      cur_idx_r  <= '0;
      hold_cnt_r <= 4'd0;
      grant      <= '0;
      wr_done    <= '0;
      addr       <= 32'd0;
      din        <= 32'd0;
      we         <= 4'b0000;
      ea         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_done <= '0;
      case (state_r)
        ST_IDLE: begin
          if (sel_found_s) begin
            cur_idx_r  <= sel_idx_s;
            grant      <= ONE_HOT0 << sel_idx_s;
            addr       <= {sel_addr_s[31:2], 2'b00};
            din        <= sel_din_s;
            we         <= 4'b1111;
            ea         <= 1'b1;
            busy       <= 1'b1;
            hold_cnt_r <= HOLD_INIT;
            state_r    <= ST_WRITE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (hold_cnt_r == 4'd0) begin
            we                 <= 4'b0000;
            ea                 <= 1'b0;
            grant              <= '0;
            wr_done[cur_idx_r] <= 1'b1;
            state_r            <= ST_DONE;
          end else begin
            hold_cnt_r <= hold_cnt_r - 4'd1;
          end
        end
        ST_DONE: begin
          rr_ptr_r <= next_ptr_s;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          grant   <= '0;
          we      <= 4'b0000;
          ea      <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_write_arbiter.sv
// Bench for bram_write_arbiter: two instances (3 requesters / 4-cycle hold and
// 2 requesters / 1-cycle hold). A transaction-level reference model predicts
// each write (owner, masked address, data, first cycle). A monitor compares
// every output against that schedule each cycle.
module tb_bram_write_arbiter;

  localparam int NR0 = 3;
  localparam int WR0 = 4;
  localparam int NR1 = 2;
  localparam int WR1 = 1;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [31:0] din;
    int          start;
  } exp_t;

  logic clock;
  logic rst_v [2];
  logic [7:0]  req_v [2];
  logic [31:0] ra [2][8];
  logic [31:0] rd [2][8];
  logic        end_req;

  logic [NR0-1:0]    req0, grant0, wr_done0;
  logic [NR0*32-1:0] req_addr0, req_din0;
  logic [31:0]       addr0, din0;
  logic [3:0]        we0;
  logic              ea0, busy0;

  logic [NR1-1:0]    req1, grant1, wr_done1;
  logic [NR1*32-1:0] req_addr1, req_din1;
  logic [31:0]       addr1, din1;
  logic [3:0]        we1;
  logic              ea1, busy1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // pack per-requester stimulus into the flat DUT buses
  always_comb begin
    req0 = req_v[0][NR0-1:0];
    req1 = req_v[1][NR1-1:0];
    req_addr0 = '0;
    req_din0  = '0;
    req_addr1 = '0;
    req_din1  = '0;
    for (int i = 0; i < NR0; i++) begin
      req_addr0[32*i +: 32] = ra[0][i];
      req_din0[32*i +: 32]  = rd[0][i];
    end
    for (int i = 0; i < NR1; i++) begin
      req_addr1[32*i +: 32] = ra[1][i];
      req_din1[32*i +: 32]  = rd[1][i];
    end
  end

  bram_write_arbiter #(.N_REQ(NR0), .WR_CYCLES(WR0)) dut0 (
    .clock(clock), .reset(rst_v[0]), .req(req0), .req_addr(req_addr0), .req_din(req_din0),
    .grant(grant0), .wr_done(wr_done0), .addr(addr0), .din(din0), .we(we0), .ea(ea0), .busy(busy0)
  );

  bram_write_arbiter #(.N_REQ(NR1), .WR_CYCLES(WR1)) dut1 (
    .clock(clock), .reset(rst_v[1]), .req(req1), .req_addr(req_addr1), .req_din(req_din1),
    .grant(grant1), .wr_done(wr_done1), .addr(addr1), .din(din1), .we(we1), .ea(ea1), .busy(busy1)
  );

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cfg%0d cyc=%0d actual=%h required=%h", nm, c, cyc, act, req);
    end
  endtask

  // reference model (posedge) and monitor (negedge) in one process
  initial begin
    exp_t        q0 [$];
    exp_t        q1 [$];
    exp_t        cur [2];
    exp_t        e;
    int          next_arb [2];
    int          ptr [2];
    logic        rst_smp [2];
    logic        act [2];
    int          nr, wr, sel, j;
    logic        found, in_wr, at_dn;
    logic [7:0]  g_v, d_v, exp_g, exp_d;
    logic [3:0]  we_v;
    logic        ea_v, bz_v;
    logic [31:0] ad_v, dn_v;
    for (int c = 0; c < 2; c++) begin
      next_arb[c] = 0; ptr[c] = 0; rst_smp[c] = 1'b1; act[c] = 1'b0;
    end
    while (!end_req) begin
      @(posedge clock);
      for (int c = 0; c < 2; c++) begin
        nr = (c == 0) ? NR0 : NR1;
        wr = (c == 0) ? WR0 : WR1;
        rst_smp[c] = rst_v[c];
        if (rst_v[c]) begin
          next_arb[c] = cyc + 1;
          ptr[c] = 0;
          if (c == 0) q0.delete(); else q1.delete();
        end else if (cyc >= next_arb[c]) begin
          found = 1'b0;
          sel = 0;
          for (int k = 0; k < nr; k++) begin
            j = (ptr[c] + k) % nr;
            if (!found && req_v[c][j]) begin
              found = 1'b1;
              sel = j;
            end
          end
          if (found) begin
            e.idx = sel;
            e.addr = ra[c][sel] & 32'hFFFF_FFFC;
            e.din = rd[c][sel];
            e.start = cyc + 1;
            if (c == 0) q0.push_back(e); else q1.push_back(e);
            ptr[c] = (sel + 1) % nr;
            next_arb[c] = cyc + wr + 2;
          end else begin
            next_arb[c] = cyc + 1;
          end
        end
      end
      cyc++;

      @(negedge clock);
      for (int c = 0; c < 2; c++) begin
        wr = (c == 0) ? WR0 : WR1;
        if (c == 0) begin
          g_v = 8'(grant0); d_v = 8'(wr_done0); we_v = we0; ea_v = ea0; bz_v = busy0;
          ad_v = addr0; dn_v = din0;
        end else begin
          g_v = 8'(grant1); d_v = 8'(wr_done1); we_v = we1; ea_v = ea1; bz_v = busy1;
          ad_v = addr1; dn_v = din1;
        end
        if (rst_smp[c]) begin
          chk("reset_ctl", c, 32'({g_v, d_v, we_v, ea_v, bz_v}), 32'd0);
          chk("reset_addr", c, ad_v, 32'd0);
          chk("reset_din", c, dn_v, 32'd0);
          act[c] = 1'b0;
        end else begin
          if (!act[c]) begin
            if (c == 0 && q0.size() > 0 && q0[0].start == cyc) begin
              cur[c] = q0.pop_front(); act[c] = 1'b1;
            end else if (c == 1 && q1.size() > 0 && q1[0].start == cyc) begin
              cur[c] = q1.pop_front(); act[c] = 1'b1;
            end
          end
          in_wr = act[c] && (cyc < cur[c].start + wr);
          at_dn = act[c] && (cyc == cur[c].start + wr);
          exp_g = in_wr ? (8'(1) << cur[c].idx) : 8'd0;
          exp_d = at_dn ? (8'(1) << cur[c].idx) : 8'd0;
          chk("grant", c, 32'(g_v), 32'(exp_g));
          chk("wr_done", c, 32'(d_v), 32'(exp_d));
          chk("we_ea_busy", c, 32'({we_v, ea_v, bz_v}),
              32'({(in_wr ? 4'hF : 4'h0), in_wr, (in_wr || at_dn)}));
          if (in_wr || at_dn) begin
            chk("addr", c, ad_v, cur[c].addr);
            chk("din", c, dn_v, cur[c].din);
          end
          if (at_dn) act[c] = 1'b0;
        end
      end
    end
    chk("drain", 0, 32'(q0.size() + q1.size() + int'(act[0]) + int'(act[1])), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // directed scenarios followed by randomized traffic on both instances
  initial begin
    int nr;
    end_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      rst_v[c] = 1'b1;
      req_v[c] = 8'h00;
      for (int i = 0; i < 8; i++) begin
        ra[c][i] = 32'h0;
        rd[c][i] = 32'h0;
      end
    end
    step(3);
    rst_v[0] = 1'b0;
    // single write from requester 0
    ra[0][0] = 32'h0000_0008; rd[0][0] = 32'hDEAD_BEEF;
    req_v[0] = 8'h01; step(6); req_v[0] = 8'h00; step(4);
    // all three requesting through reset release
    rst_v[0] = 1'b1;
    ra[0][0] = 32'h0000_0100; rd[0][0] = 32'h1111_0000;
    ra[0][1] = 32'h0000_0204; rd[0][1] = 32'h2222_0001;
    ra[0][2] = 32'h0000_0308; rd[0][2] = 32'h3333_0002;
    req_v[0] = 8'h07; step(2); rst_v[0] = 1'b0; step(24);
    req_v[0] = 8'h00; step(4);
    // unaligned address, request dropped in the middle of the write
    ra[0][0] = 32'h0000_0007; rd[0][0] = 32'hA5A5_5A5A;
    req_v[0] = 8'h01; step(3); req_v[0] = 8'h00; step(8);
    // reset during the write, requester 1 pending afterwards
    req_v[0] = 8'h01; step(3);
    rst_v[0] = 1'b1; req_v[0] = 8'h02; step(1);
    rst_v[0] = 1'b0; step(6); req_v[0] = 8'h00; step(4);
    // data and address change after capture
    ra[0][2] = 32'h0000_0040; rd[0][2] = 32'h1234_5678;
    req_v[0] = 8'h04; step(2);
    ra[0][2] = 32'h0000_0080; rd[0][2] = 32'hCAFE_F00D;
    step(4); req_v[0] = 8'h00; step(4);
    // two requesters with 1-cycle hold, continuous requests
    rst_v[1] = 1'b0;
    ra[1][0] = 32'h0000_1000; rd[1][0] = 32'h0BAD_0000;
    ra[1][1] = 32'h0000_2002; rd[1][1] = 32'h0BAD_0001;
    req_v[1] = 8'h03; step(30); req_v[1] = 8'h00; step(3);
    // randomized traffic with occasional resets
    for (int it = 0; it < 700; it++) begin
      for (int c = 0; c < 2; c++) begin
        nr = (c == 0) ? NR0 : NR1;
        if ($urandom_range(0, 3) == 0) req_v[c] = 8'($urandom) & ((c == 0) ? 8'h07 : 8'h03);
        if ($urandom_range(0, 3) == 0) ra[c][$urandom_range(0, nr - 1)] = $urandom;
        if ($urandom_range(0, 3) == 0) rd[c][$urandom_range(0, nr - 1)] = $urandom;
        rst_v[c] = ($urandom_range(0, 99) == 0);
      end
      step(1);
    end
    for (int c = 0; c < 2; c++) begin
      rst_v[c] = 1'b0;
      req_v[c] = 8'h00;
    end
    step(12);
    end_req = 1'b1;
  end

endmodule
